// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multicycle controller and the shared RV datapath and memories.
interface multicycle_ctrl_if #(
  parameter int unsigned RET_W = 32
);
  logic [4:0]       OpCode;
  logic             BrTaken;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             IrWrite;
  logic             PcWrite;
  logic [1:0]       PcSrc;
  logic [2:0]       ImmSel;
  logic             AluSrcB;
  logic [1:0]       AluOp;
  logic             RegWrite;
  logic [1:0]       MemToReg;
  logic [2:0]       State;
  logic [1:0]       Fault;
  logic [RET_W-1:0] RetireCount;

  modport master (
    input  OpCode, BrTaken, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, IrWrite, PcWrite, PcSrc, ImmSel,
           AluSrcB, AluOp, RegWrite, MemToReg, State, Fault, RetireCount
  );

  modport slave (
    output OpCode, BrTaken, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, IrWrite, PcWrite, PcSrc, ImmSel,
           AluSrcB, AluOp, RegWrite, MemToReg, State, Fault, RetireCount
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV control FSM: fetch/decode/exec/mem/wb sequencing, memory handshakes
// with per-access timeout, retired-instruction counter and sticky fault reporting.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RET_W       = 32
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  localparam int unsigned TO_W = $clog2(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_FAULT  = 3'b111
  } state_t;

  typedef enum logic [3:0] {
    C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
  } cls_t;

  // Major opcode to instruction class; anything outside the legal set is illegal.
  function automatic cls_t decode(input logic [4:0] op);
    case (op)
      5'b01100: return C_OP;
      5'b00100: return C_OPIMM;
      5'b00000: return C_LOAD;
      5'b01000: return C_STORE;
      5'b11000: return C_BRANCH;
      5'b11011: return C_JAL;
      5'b11001: return C_JALR;
      5'b01101: return C_LUI;
      5'b00101: return C_AUIPC;
      default:  return C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input cls_t c);
    case (c)
      C_OPIMM, C_LOAD, C_JALR: return 3'b000;
      C_STORE:                 return 3'b001;
      C_BRANCH:                return 3'b010;
      C_LUI, C_AUIPC:          return 3'b011;
      C_JAL:                   return 3'b100;
      default:                 return 3'b111;
    endcase
  endfunction

  state_t           state, state_next;
  cls_t             cls, dec_cls;
  logic [TO_W-1:0]  to_cnt;
  logic [1:0]       fault, fault_next;
  logic [RET_W-1:0] ret_cnt;
  logic             retire_c;

  logic       imem_req_c, dmem_req_c, dmem_we_c, ir_write_c, pc_write_c;
  logic       alu_src_b_c, reg_write_c;
  logic [1:0] pc_src_c, alu_op_c, mem_to_reg_c;
  logic [2:0] imm_sel_c;

  assign dec_cls = decode(bus.OpCode);

  // State, class, timeout, fault and retire registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      cls     <= C_ILL;
      to_cnt  <= '0;
      fault   <= 2'b00;
      ret_cnt <= '0;
    end else begin
      state <= state_next;
      fault <= fault_next;
      if (state == S_DECODE) cls <= dec_cls;
      if (state_next != state)                     to_cnt <= '0;
      else if (state == S_FETCH || state == S_MEM) to_cnt <= to_cnt + TO_W'(1);
      if (retire_c) ret_cnt <= ret_cnt + RET_W'(1);
    end
  end

  // Next state and datapath strobes; reset holds every strobe low.
  always_comb begin
    state_next   = state;
    fault_next   = fault;
    retire_c     = 1'b0;
    imem_req_c   = 1'b0;
    dmem_req_c   = 1'b0;
    dmem_we_c    = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = 2'b00;
    imm_sel_c    = 3'b111;
    alu_src_b_c  = 1'b0;
    alu_op_c     = 2'b00;
    reg_write_c  = 1'b0;
    mem_to_reg_c = 2'b00;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          imem_req_c = 1'b1;
          if (bus.imem_ack) begin
            ir_write_c = 1'b1;
            pc_write_c = 1'b1;
            state_next = S_DECODE;
          end else if (to_cnt == TO_LAST) begin
            fault_next = 2'b10;
            state_next = S_FAULT;
          end
        end
        S_DECODE: begin
          imm_sel_c = imm_of(dec_cls);
          if (dec_cls == C_ILL) begin
            fault_next = 2'b01;
            state_next = S_FAULT;
          end else begin
            state_next = S_EXEC;
          end
        end
        S_EXEC: begin
          imm_sel_c  = imm_of(cls);
          state_next = S_WB;
          case (cls)
            C_OP:    alu_op_c = 2'b10;
            C_OPIMM: begin alu_src_b_c = 1'b1; alu_op_c = 2'b10; end
            C_LOAD, C_STORE: begin
              alu_src_b_c = 1'b1;
              state_next  = S_MEM;
            end
            C_BRANCH: begin
              alu_op_c   = 2'b01;
              retire_c   = 1'b1;
              state_next = S_FETCH;
              if (bus.BrTaken) begin
                pc_write_c = 1'b1;
                pc_src_c   = 2'b01;
              end
            end
            C_JAL: begin pc_write_c = 1'b1; pc_src_c = 2'b01; end
            C_JALR: begin
              alu_src_b_c = 1'b1;
              pc_write_c  = 1'b1;
              pc_src_c    = 2'b10;
            end
            C_LUI, C_AUIPC: alu_src_b_c = 1'b1;
            default: state_next = S_FAULT;
          endcase
        end
        S_MEM: begin
          imm_sel_c  = imm_of(cls);
          dmem_req_c = 1'b1;
          dmem_we_c  = (cls == C_STORE);
          if (bus.dmem_ack) begin
            if (cls == C_STORE) begin
              retire_c   = 1'b1;
              state_next = S_FETCH;
            end else begin
              state_next = S_WB;
            end
          end else if (to_cnt == TO_LAST) begin
            fault_next = 2'b11;
            state_next = S_FAULT;
          end
        end
        S_WB: begin
          imm_sel_c   = imm_of(cls);
          reg_write_c = 1'b1;
          retire_c    = 1'b1;
          state_next  = S_FETCH;
          if (cls == C_LOAD)                       mem_to_reg_c = 2'b01;
          else if (cls == C_JAL || cls == C_JALR) mem_to_reg_c = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_req    = imem_req_c;
  assign bus.dmem_req    = dmem_req_c;
  assign bus.dmem_we     = dmem_we_c;
  assign bus.IrWrite     = ir_write_c;
  assign bus.PcWrite     = pc_write_c;
  assign bus.PcSrc       = pc_src_c;
  assign bus.ImmSel      = imm_sel_c;
  assign bus.AluSrcB     = alu_src_b_c;
  assign bus.AluOp       = alu_op_c;
  assign bus.RegWrite    = reg_write_c;
  assign bus.MemToReg    = mem_to_reg_c;
  assign bus.State       = state;
  assign bus.Fault       = fault;
  assign bus.RetireCount = ret_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  localparam logic [2:0] SF = 3'b000, SD = 3'b001, SE = 3'b010, SM = 3'b011, SW = 3'b100, SX = 3'b111;
  localparam logic [4:0] OP = 5'b01100, OPI = 5'b00100, LD = 5'b00000, ST = 5'b01000,
                         BR = 5'b11000, JAL = 5'b11011, JALR = 5'b11001, LUI = 5'b01101,
                         AUI = 5'b00101, BAD = 5'b11111;

  logic clk;
  logic rst;
  multicycle_ctrl_if #(.RET_W(4)) bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(16), .RET_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [24:0] obs;
  assign obs = {bus.State, bus.Fault, bus.RetireCount, bus.imem_req, bus.dmem_req, bus.dmem_we,
                bus.IrWrite, bus.PcWrite, bus.PcSrc, bus.ImmSel, bus.AluSrcB, bus.AluOp,
                bus.RegWrite, bus.MemToReg};

  logic [24:0] q_val[$];
  string       q_nm[$];
  int          n_cmp;
  int          n_bad;

  // Packs {State, Fault, RetireCount, imem_req, dmem_req, dmem_we, IrWrite, PcWrite,
  // PcSrc, ImmSel, AluSrcB, AluOp, RegWrite, MemToReg}.
  function automatic logic [24:0] v(input logic [2:0] st, input logic [1:0] flt, input logic [3:0] rc,
                                    input logic imem, input logic dmem, input logic we,
                                    input logic irw, input logic pcw, input logic [1:0] pcs,
                                    input logic [2:0] imm, input logic asb, input logic [1:0] aop,
                                    input logic rw, input logic [1:0] m2r);
    return {st, flt, rc, imem, dmem, we, irw, pcw, pcs, imm, asb, aop, rw, m2r};
  endfunction

  function automatic logic [24:0] idle(input logic [2:0] st, input logic [1:0] flt, input logic [3:0] rc);
    return v(st, flt, rc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b111, 1'b0, 2'b00, 1'b0, 2'b00);
  endfunction

  function automatic logic [24:0] fa(input logic [3:0] rc);
    return v(SF, 2'b00, rc, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b111, 1'b0, 2'b00, 1'b0, 2'b00);
  endfunction

  function automatic logic [24:0] fw(input logic [3:0] rc);
    return v(SF, 2'b00, rc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b111, 1'b0, 2'b00, 1'b0, 2'b00);
  endfunction

  function automatic logic [24:0] dec(input logic [3:0] rc, input logic [2:0] imm);
    return v(SD, 2'b00, rc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, imm, 1'b0, 2'b00, 1'b0, 2'b00);
  endfunction

  task automatic cyc(input logic r, input logic ai, input logic ad, input logic br,
                     input logic [4:0] op, input string nm, input logic [24:0] e);
    @(posedge clk);
    #1;
    rst          = r;
    bus.imem_ack = ai;
    bus.dmem_ack = ad;
    bus.BrTaken  = br;
    bus.OpCode   = op;
    q_val.push_back(e);
    q_nm.push_back(nm);
  endtask

  // Monitor: one comparison per queued expectation, sampled mid-cycle.
  initial begin
    logic [24:0] e;
    string       nm;
    n_cmp = 0;
    n_bad = 0;
    forever begin
      @(negedge clk);
      if (q_val.size() > 0) begin
        e  = q_val.pop_front();
        nm = q_nm.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL %s @%0t: got %h expected %h", nm, $time, obs, e);
        end
      end
    end
  end

  initial begin
    rst          = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.BrTaken  = 1'b0;
    bus.OpCode   = 5'b00000;

    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, OP, "reset", idle(SF, 2'b00, 4'd0));

    // OP, immediate fetch ack; stray acks in DECODE ignored
    cyc(0, 1, 0, 0, OP, "op_fetch", fa(4'd0));
    cyc(0, 1, 1, 0, OP, "op_decode", dec(4'd0, 3'b111));
    cyc(0, 0, 0, 0, OP, "op_exec", v(SE, 2'b00, 4'd0, 0, 0, 0, 0, 0, 2'b00, 3'b111, 0, 2'b10, 0, 2'b00));
    cyc(0, 0, 0, 0, OP, "op_wb", v(SW, 2'b00, 4'd0, 0, 0, 0, 0, 0, 2'b00, 3'b111, 0, 2'b00, 1, 2'b00));

    // LOAD with dmem ack on the fourth MEM cycle
    cyc(0, 1, 1, 0, LD, "ld_fetch", fa(4'd1));
    cyc(0, 0, 0, 0, LD, "ld_decode", dec(4'd1, 3'b000));
    cyc(0, 0, 0, 0, LD, "ld_exec", v(SE, 2'b00, 4'd1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 2'b00, 0, 2'b00));
    for (int i = 0; i < 4; i++)
      cyc(0, 0, (i == 3), 0, LD, "ld_mem", v(SM, 2'b00, 4'd1, 0, 1, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 0, 2'b00));
    cyc(0, 0, 0, 0, LD, "ld_wb", v(SW, 2'b00, 4'd1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 1, 2'b01));

    // STORE with single-cycle ack
    cyc(0, 1, 0, 0, ST, "st_fetch", fa(4'd2));
    cyc(0, 0, 0, 0, ST, "st_decode", dec(4'd2, 3'b001));
    cyc(0, 0, 0, 0, ST, "st_exec", v(SE, 2'b00, 4'd2, 0, 0, 0, 0, 0, 2'b00, 3'b001, 1, 2'b00, 0, 2'b00));
    cyc(0, 0, 1, 0, ST, "st_mem", v(SM, 2'b00, 4'd2, 0, 1, 1, 0, 0, 2'b00, 3'b001, 0, 2'b00, 0, 2'b00));

    // BRANCH taken then not taken
    cyc(0, 1, 0, 0, BR, "bt_fetch", fa(4'd3));
    cyc(0, 0, 0, 0, BR, "bt_decode", dec(4'd3, 3'b010));
    cyc(0, 0, 0, 1, BR, "bt_exec", v(SE, 2'b00, 4'd3, 0, 0, 0, 0, 1, 2'b01, 3'b010, 0, 2'b01, 0, 2'b00));
    cyc(0, 1, 0, 0, BR, "bn_fetch", fa(4'd4));
    cyc(0, 0, 0, 0, BR, "bn_decode", dec(4'd4, 3'b010));
    cyc(0, 0, 0, 0, BR, "bn_exec", v(SE, 2'b00, 4'd4, 0, 0, 0, 0, 0, 2'b00, 3'b010, 0, 2'b01, 0, 2'b00));

    // JAL, JALR, LUI, OP-IMM, AUIPC
    cyc(0, 1, 0, 0, JAL, "jal_fetch", fa(4'd5));
    cyc(0, 0, 0, 0, JAL, "jal_decode", dec(4'd5, 3'b100));
    cyc(0, 0, 0, 0, JAL, "jal_exec", v(SE, 2'b00, 4'd5, 0, 0, 0, 0, 1, 2'b01, 3'b100, 0, 2'b00, 0, 2'b00));
    cyc(0, 0, 0, 0, JAL, "jal_wb", v(SW, 2'b00, 4'd5, 0, 0, 0, 0, 0, 2'b00, 3'b100, 0, 2'b00, 1, 2'b10));
    cyc(0, 1, 0, 0, JALR, "jalr_fetch", fa(4'd6));
    cyc(0, 0, 0, 0, JALR, "jalr_decode", dec(4'd6, 3'b000));
    cyc(0, 0, 0, 0, JALR, "jalr_exec", v(SE, 2'b00, 4'd6, 0, 0, 0, 0, 1, 2'b10, 3'b000, 1, 2'b00, 0, 2'b00));
    cyc(0, 0, 0, 0, JALR, "jalr_wb", v(SW, 2'b00, 4'd6, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 1, 2'b10));
    cyc(0, 1, 0, 0, LUI, "lui_fetch", fa(4'd7));
    cyc(0, 0, 0, 0, LUI, "lui_decode", dec(4'd7, 3'b011));
    cyc(0, 0, 0, 0, LUI, "lui_exec", v(SE, 2'b00, 4'd7, 0, 0, 0, 0, 0, 2'b00, 3'b011, 1, 2'b00, 0, 2'b00));
    cyc(0, 0, 0, 0, LUI, "lui_wb", v(SW, 2'b00, 4'd7, 0, 0, 0, 0, 0, 2'b00, 3'b011, 0, 2'b00, 1, 2'b00));
    cyc(0, 1, 0, 0, OPI, "opi_fetch", fa(4'd8));
    cyc(0, 0, 0, 0, OPI, "opi_decode", dec(4'd8, 3'b000));
    cyc(0, 0, 0, 0, OPI, "opi_exec", v(SE, 2'b00, 4'd8, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 2'b10, 0, 2'b00));
    cyc(0, 0, 0, 0, OPI, "opi_wb", v(SW, 2'b00, 4'd8, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 1, 2'b00));
    cyc(0, 1, 0, 0, AUI, "aui_fetch", fa(4'd9));
    cyc(0, 0, 0, 0, AUI, "aui_decode", dec(4'd9, 3'b011));
    cyc(0, 0, 0, 0, AUI, "aui_exec", v(SE, 2'b00, 4'd9, 0, 0, 0, 0, 0, 2'b00, 3'b011, 1, 2'b00, 0, 2'b00));
    cyc(0, 0, 0, 0, AUI, "aui_wb", v(SW, 2'b00, 4'd9, 0, 0, 0, 0, 0, 2'b00, 3'b011, 0, 2'b00, 1, 2'b00));

    // imem ack on the 16th waiting cycle wins over the timeout
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, OP, "fetch_wait", fw(4'd10));
    cyc(0, 1, 0, 0, OP, "fetch_ack_limit", fa(4'd10));
    cyc(0, 0, 0, 0, OP, "late_decode", dec(4'd10, 3'b111));
    cyc(0, 0, 0, 0, OP, "late_exec", v(SE, 2'b00, 4'd10, 0, 0, 0, 0, 0, 2'b00, 3'b111, 0, 2'b10, 0, 2'b00));
    cyc(0, 0, 0, 0, OP, "late_wb", v(SW, 2'b00, 4'd10, 0, 0, 0, 0, 0, 2'b00, 3'b111, 0, 2'b00, 1, 2'b00));

    // imem timeout: FAULT 16 cycles after FETCH entry, sticky, acks ignored
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, LD, "imem_wait", fw(4'd11));
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, LD, "imem_fault", idle(SX, 2'b10, 4'd11));
    cyc(1, 0, 0, 0, LD, "imem_fault_rst", idle(SX, 2'b10, 4'd11));

    // illegal opcode
    cyc(0, 1, 0, 0, BAD, "ill_fetch", fa(4'd0));
    cyc(0, 0, 0, 0, BAD, "ill_decode", dec(4'd0, 3'b111));
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 1, OP, "ill_fault", idle(SX, 2'b01, 4'd0));
    cyc(1, 0, 0, 0, OP, "ill_rst", idle(SX, 2'b01, 4'd0));

    // dmem timeout on a STORE
    cyc(0, 1, 0, 0, ST, "dto_fetch", fa(4'd0));
    cyc(0, 0, 0, 0, ST, "dto_decode", dec(4'd0, 3'b001));
    cyc(0, 0, 0, 0, ST, "dto_exec", v(SE, 2'b00, 4'd0, 0, 0, 0, 0, 0, 2'b00, 3'b001, 1, 2'b00, 0, 2'b00));
    for (int i = 0; i < 16; i++)
      cyc(0, 0, 0, 0, ST, "dto_mem", v(SM, 2'b00, 4'd0, 0, 1, 1, 0, 0, 2'b00, 3'b001, 0, 2'b00, 0, 2'b00));
    for (int i = 0; i < 2; i++) cyc(0, 1, 1, 0, ST, "dmem_fault", idle(SX, 2'b11, 4'd0));
    cyc(1, 0, 0, 0, OP, "dmem_fault_rst", idle(SX, 2'b11, 4'd0));

    // 17 OPs: RetireCount wraps 15 -> 0 -> 1
    for (int i = 0; i < 17; i++) begin
      cyc(0, 1, 0, 0, OP, "wrap_fetch", fa(4'(i)));
      cyc(0, 0, 0, 0, OP, "wrap_decode", dec(4'(i), 3'b111));
      cyc(0, 0, 0, 0, OP, "wrap_exec", v(SE, 2'b00, 4'(i), 0, 0, 0, 0, 0, 2'b00, 3'b111, 0, 2'b10, 0, 2'b00));
      cyc(0, 0, 0, 0, OP, "wrap_wb", v(SW, 2'b00, 4'(i), 0, 0, 0, 0, 0, 2'b00, 3'b111, 0, 2'b00, 1, 2'b00));
    end

    // reset mid-MEM aborts the data request
    cyc(0, 1, 0, 0, LD, "abort_fetch", fa(4'd1));
    cyc(0, 0, 0, 0, LD, "abort_decode", dec(4'd1, 3'b000));
    cyc(0, 0, 0, 0, LD, "abort_exec", v(SE, 2'b00, 4'd1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 2'b00, 0, 2'b00));
    cyc(0, 0, 0, 0, LD, "abort_mem", v(SM, 2'b00, 4'd1, 0, 1, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 0, 2'b00));
    cyc(1, 0, 0, 0, LD, "abort_rst", idle(SM, 2'b00, 4'd1));
    cyc(0, 0, 0, 0, LD, "abort_after", fw(4'd0));

    repeat (2) @(negedge clk);
    if (q_val.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q_val.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
